// File: rtl/load_store_pipe_responder_pkg.sv
// -----------------------------------------------------------------------------
// load_store_pipe_responder_pkg
// Shared encodings for the LDST responder and its lane-alignment helper:
//   - ORDER_* : access size encodings carried on the LDST/DATAIO order fields
//   - ST_*    : responder state encodings
//   - MISALIGN_FLAG_BIT : MMU flag bit raised for a misaligned access
//   - is_misaligned()   : halfword on odd byte / word on non-word boundary
// -----------------------------------------------------------------------------
package load_store_pipe_responder_pkg;

   localparam logic [1:0] ORDER_BYTE = 2'b00;
   localparam logic [1:0] ORDER_HALF = 2'b01;
   localparam logic [1:0] ORDER_WORD = 2'b10;
   localparam logic [1:0] ORDER_NONE = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT     = 2'd2;
   localparam logic [1:0] ST_DONE_NOP = 2'd3;

   localparam int MISALIGN_FLAG_BIT = 0;

   function automatic logic is_misaligned(input logic [1:0] order, input logic [1:0] addr_lo);
      return ((order == ORDER_HALF) && addr_lo[0]) ||
             ((order == ORDER_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/load_store_pipe_responder_ldst_lane_align.sv
// -----------------------------------------------------------------------------
// ldst_lane_align
// Purely combinational big-endian byte-lane logic (lane 0 = bits [31:24]).
// Ports:
//   order     in  2   access size (byte/half/word/none)
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  right-justified write data
//   rdata_raw in  32  raw word from memory
//   lane_en   out 4   byte lanes touched by the access
//   wdata_lane out 32 write data replicated onto every candidate lane
//   rdata_ext out 32  selected lane(s) right-justified, zero-extended
// -----------------------------------------------------------------------------
module ldst_lane_align
   import load_store_pipe_responder_pkg::*;
(
   input  logic [1:0]  order,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  lane_en,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [31:0] byte_shift;

   always_comb begin
      lane_en    = 4'b0000;
      wdata_lane = wdata;
      rdata_ext  = 32'd0;
      // (3 - addr_lo) * 8 : bring the addressed byte down to [7:0]
      byte_shift = rdata_raw >> {~addr_lo, 3'b000};
      case (order)
         ORDER_BYTE: begin
            lane_en    = 4'b1000 >> addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {24'd0, byte_shift[7:0]};
         end
         ORDER_HALF: begin
            lane_en    = addr_lo[1] ? 4'b0011 : 4'b1100;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = addr_lo[1] ? {16'd0, rdata_raw[15:0]} : {16'd0, rdata_raw[31:16]};
         end
         ORDER_WORD: begin
            lane_en    = 4'b1111;
            rdata_ext  = rdata_raw;
         end
         default: begin
            lane_en    = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/load_store_pipe_responder.sv
// -----------------------------------------------------------------------------
// load_store_pipe_responder
// Responder end of the LDST pipe: accepts one request at a time, drives the
// DATAIO memory port with lane-aligned enables/data, waits for completion and
// returns right-justified read data, fault status and MMU flags with a
// one-cycle oLDST_VALID pulse.
// Optional: define LDST_ALIGN_CHECK_EN to fault misaligned half/word accesses
// without touching memory (PAGEFAULT=1, flag bit0 = misalign code).
// Ports:
//   iCLOCK, inRESET (async, active low)
//   iLDST_*  / oLDST_*   : request in, busy/result out
//   oDATAIO_* / iDATAIO_* : memory request out, stall/completion in
// -----------------------------------------------------------------------------
module load_store_pipe_responder
   import load_store_pipe_responder_pkg::*;
#(
   parameter int P_TID_W  = 14,
   parameter int P_FLAG_W = 14
)(
   input  logic                iCLOCK,
   input  logic                inRESET,
   input  logic                iLDST_REQ,
   output logic                oLDST_BUSY,
   input  logic [1:0]          iLDST_ORDER,
   input  logic [3:0]          iLDST_MASK,
   input  logic                iLDST_RW,
   input  logic [P_TID_W-1:0]  iLDST_TID,
   input  logic [1:0]          iLDST_MMUMOD,
   input  logic [31:0]         iLDST_PDT,
   input  logic [31:0]         iLDST_ADDR,
   input  logic [31:0]         iLDST_DATA,
   output logic                oLDST_VALID,
   output logic                oLDST_PAGEFAULT,
   output logic [P_FLAG_W-1:0] oLDST_MMU_FLAGS,
   output logic [31:0]         oLDST_DATA,
   output logic                oDATAIO_REQ,
   input  logic                iDATAIO_BUSY,
   output logic [1:0]          oDATAIO_ORDER,
   output logic [3:0]          oDATAIO_MASK,
   output logic                oDATAIO_RW,
   output logic [P_TID_W-1:0]  oDATAIO_TID,
   output logic [1:0]          oDATAIO_MMUMOD,
   output logic [31:0]         oDATAIO_PDT,
   output logic [31:0]         oDATAIO_ADDR,
   output logic [31:0]         oDATAIO_DATA,
   input  logic                iDATAIO_VALID,
   input  logic                iDATAIO_PAGEFAULT,
   input  logic [P_FLAG_W-1:0] iDATAIO_MMU_FLAGS,
   input  logic [31:0]         iDATAIO_DATA
);

`ifdef LDST_ALIGN_CHECK_EN
   localparam logic [P_FLAG_W-1:0] MISALIGN_FLAGS = P_FLAG_W'(1) << MISALIGN_FLAG_BIT;
`endif

   logic [1:0]          state_reg;
   logic [1:0]          order_reg;
   logic [3:0]          mask_reg;
   logic                rw_reg;
   logic [P_TID_W-1:0]  tid_reg;
   logic [1:0]          mmumod_reg;
   logic [31:0]         pdt_reg;
   logic [31:0]         addr_reg;
   logic [31:0]         wdata_reg;
   logic                valid_reg;
   logic                pf_reg;
   logic [P_FLAG_W-1:0] flags_reg;
   logic [31:0]         data_reg;

   logic [3:0]          lane_en;
   logic [31:0]         wdata_lane;
   logic [31:0]         rdata_ext;

   ldst_lane_align u_align (
      .order      (order_reg),
      .addr_lo    (addr_reg[1:0]),
      .wdata      (wdata_reg),
      .rdata_raw  (iDATAIO_DATA),
      .lane_en    (lane_en),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_reg  <= ST_IDLE;
         order_reg  <= 2'b00;
         mask_reg   <= 4'b0000;
         rw_reg     <= 1'b0;
         tid_reg    <= '0;
         mmumod_reg <= 2'b00;
         pdt_reg    <= 32'd0;
         addr_reg   <= 32'd0;
         wdata_reg  <= 32'd0;
         valid_reg  <= 1'b0;
         pf_reg     <= 1'b0;
         flags_reg  <= '0;
         data_reg   <= 32'd0;
      end else begin
         // VALID is a single-cycle pulse; only a completion re-arms it.
         valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (iLDST_REQ) begin
                  order_reg  <= iLDST_ORDER;
                  mask_reg   <= iLDST_MASK;
                  rw_reg     <= iLDST_RW;
                  tid_reg    <= iLDST_TID;
                  mmumod_reg <= iLDST_MMUMOD;
                  pdt_reg    <= iLDST_PDT;
                  addr_reg   <= iLDST_ADDR;
                  wdata_reg  <= iLDST_DATA;
`ifdef LDST_ALIGN_CHECK_EN
                  if (is_misaligned(iLDST_ORDER, iLDST_ADDR[1:0])) begin
                     state_reg <= ST_DONE_NOP;
                     valid_reg <= 1'b1;
                     pf_reg    <= 1'b1;
                     flags_reg <= MISALIGN_FLAGS;
                     data_reg  <= 32'd0;
                  end else
`endif
                  if (iLDST_ORDER == ORDER_NONE) begin
                     // No-op completes without a memory access; result is
                     // registered on entry so VALID coincides with DONE_NOP.
                     state_reg <= ST_DONE_NOP;
                     valid_reg <= 1'b1;
                     pf_reg    <= 1'b0;
                     flags_reg <= '0;
                     data_reg  <= 32'd0;
                  end else begin
                     state_reg <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (!iDATAIO_BUSY) begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (iDATAIO_VALID) begin
                  state_reg <= ST_IDLE;
                  valid_reg <= 1'b1;
                  pf_reg    <= iDATAIO_PAGEFAULT;
                  flags_reg <= iDATAIO_MMU_FLAGS;
                  data_reg  <= (iDATAIO_PAGEFAULT || rw_reg) ? 32'd0 : rdata_ext;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign oLDST_BUSY      = (state_reg != ST_IDLE);
   assign oLDST_VALID     = valid_reg;
   assign oLDST_PAGEFAULT = pf_reg;
   assign oLDST_MMU_FLAGS = flags_reg;
   assign oLDST_DATA      = data_reg;

   assign oDATAIO_REQ     = (state_reg == ST_ISSUE);
   assign oDATAIO_ORDER   = order_reg;
   assign oDATAIO_MASK    = lane_en & mask_reg;
   assign oDATAIO_RW      = rw_reg;
   assign oDATAIO_TID     = tid_reg;
   assign oDATAIO_MMUMOD  = mmumod_reg;
   assign oDATAIO_PDT     = pdt_reg;
   assign oDATAIO_ADDR    = {addr_reg[31:2], 2'b00};
   assign oDATAIO_DATA    = wdata_lane;

endmodule

// File: tb/tb_load_store_pipe_responder.sv
// -----------------------------------------------------------------------------
// tb_load_store_pipe_responder
// Directed, table-driven bench for load_store_pipe_responder plus hand-written
// sequences for stall, no-op, reset-abort and (optionally) misalign handling.
// -----------------------------------------------------------------------------
module tb_load_store_pipe_responder;

   logic        clk;
   logic        rst_n;
   logic        ldst_req;
   logic        ldst_busy;
   logic [1:0]  ldst_order;
   logic [3:0]  ldst_mask;
   logic        ldst_rw;
   logic [13:0] ldst_tid;
   logic [1:0]  ldst_mmumod;
   logic [31:0] ldst_pdt;
   logic [31:0] ldst_addr;
   logic [31:0] ldst_wdata;
   logic        ldst_valid;
   logic        ldst_pf;
   logic [13:0] ldst_flags;
   logic [31:0] ldst_rdata;
   logic        dio_req;
   logic        dio_busy;
   logic [1:0]  dio_order;
   logic [3:0]  dio_mask;
   logic        dio_rw;
   logic [13:0] dio_tid;
   logic [1:0]  dio_mmumod;
   logic [31:0] dio_pdt;
   logic [31:0] dio_addr;
   logic [31:0] dio_wdata;
   logic        dio_valid;
   logic        dio_pf;
   logic [13:0] dio_flags;
   logic [31:0] dio_rdata;

   int checks = 0;
   int errors = 0;

   load_store_pipe_responder #(.P_TID_W(14), .P_FLAG_W(14)) dut (
      .iCLOCK            (clk),
      .inRESET           (rst_n),
      .iLDST_REQ         (ldst_req),
      .oLDST_BUSY        (ldst_busy),
      .iLDST_ORDER       (ldst_order),
      .iLDST_MASK        (ldst_mask),
      .iLDST_RW          (ldst_rw),
      .iLDST_TID         (ldst_tid),
      .iLDST_MMUMOD      (ldst_mmumod),
      .iLDST_PDT         (ldst_pdt),
      .iLDST_ADDR        (ldst_addr),
      .iLDST_DATA        (ldst_wdata),
      .oLDST_VALID       (ldst_valid),
      .oLDST_PAGEFAULT   (ldst_pf),
      .oLDST_MMU_FLAGS   (ldst_flags),
      .oLDST_DATA        (ldst_rdata),
      .oDATAIO_REQ       (dio_req),
      .iDATAIO_BUSY      (dio_busy),
      .oDATAIO_ORDER     (dio_order),
      .oDATAIO_MASK      (dio_mask),
      .oDATAIO_RW        (dio_rw),
      .oDATAIO_TID       (dio_tid),
      .oDATAIO_MMUMOD    (dio_mmumod),
      .oDATAIO_PDT       (dio_pdt),
      .oDATAIO_ADDR      (dio_addr),
      .oDATAIO_DATA      (dio_wdata),
      .iDATAIO_VALID     (dio_valid),
      .iDATAIO_PAGEFAULT (dio_pf),
      .iDATAIO_MMU_FLAGS (dio_flags),
      .iDATAIO_DATA      (dio_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  order;
      logic [3:0]  mask;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        pf;
      logic [13:0] flags;
      int          stall;
      logic [31:0] e_daddr;
      logic [3:0]  e_dmask;
      logic [31:0] e_dwdata;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Entered and left on a negedge. Request is presented immediately, so a
   // call made on the VALID cycle of the previous transaction also exercises
   // acceptance in that same cycle.
   task automatic run_txn(input int idx, input vec_t v);
      ldst_req    = 1'b1;
      ldst_order  = v.order;
      ldst_mask   = v.mask;
      ldst_rw     = v.rw;
      ldst_tid    = 14'h0100 + 14'(idx);
      ldst_mmumod = 2'b10;
      ldst_pdt    = 32'hABCD_0000 + 32'(idx);
      ldst_addr   = v.addr;
      ldst_wdata  = v.wdata;
      @(negedge clk);
      // Scramble the inputs: the responder must work from latched copies.
      ldst_req   = 1'b0;
      ldst_order = 2'b10;
      ldst_mask  = 4'b0000;
      ldst_addr  = 32'hFFFF_FFFF;
      ldst_wdata = 32'h5A5A_5A5A;
      ldst_rw    = ~v.rw;
      chk($sformatf("v%0d issue_req", idx), 32'(dio_req), 32'd1);
      chk($sformatf("v%0d issue_busy", idx), 32'(ldst_busy), 32'd1);
      chk($sformatf("v%0d daddr", idx), dio_addr, v.e_daddr);
      chk($sformatf("v%0d dmask", idx), 32'(dio_mask), 32'(v.e_dmask));
      chk($sformatf("v%0d dwdata", idx), dio_wdata, v.e_dwdata);
      chk($sformatf("v%0d drw", idx), 32'(dio_rw), 32'(v.rw));
      chk($sformatf("v%0d dorder", idx), 32'(dio_order), 32'(v.order));
      chk($sformatf("v%0d dtid", idx), 32'(dio_tid), 32'h0100 + 32'(idx));
      chk($sformatf("v%0d dpdt", idx), dio_pdt, 32'hABCD_0000 + 32'(idx));
      chk($sformatf("v%0d dmmumod", idx), 32'(dio_mmumod), 32'd2);
      dio_busy = (v.stall > 0);
      for (int i = 0; i < v.stall; i++) begin
         // A second request mid-stall must be ignored.
         ldst_req = (i == 0);
         @(negedge clk);
         ldst_req = 1'b0;
         chk($sformatf("v%0d stall%0d req", idx, i), 32'(dio_req), 32'd1);
         chk($sformatf("v%0d stall%0d busy", idx, i), 32'(ldst_busy), 32'd1);
         chk($sformatf("v%0d stall%0d daddr", idx, i), dio_addr, v.e_daddr);
         chk($sformatf("v%0d stall%0d dmask", idx, i), 32'(dio_mask), 32'(v.e_dmask));
         chk($sformatf("v%0d stall%0d dwdata", idx, i), dio_wdata, v.e_dwdata);
         if (i == v.stall - 1) dio_busy = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d wait_req", idx), 32'(dio_req), 32'd0);
      chk($sformatf("v%0d wait_busy", idx), 32'(ldst_busy), 32'd1);
      chk($sformatf("v%0d wait_valid", idx), 32'(ldst_valid), 32'd0);
      dio_valid = 1'b1;
      dio_rdata = v.rdata;
      dio_pf    = v.pf;
      dio_flags = v.flags;
      @(negedge clk);
      dio_valid = 1'b0;
      dio_rdata = 32'h0BAD_F00D;
      dio_pf    = 1'b0;
      dio_flags = 14'h3FFF;
      chk($sformatf("v%0d valid", idx), 32'(ldst_valid), 32'd1);
      chk($sformatf("v%0d data", idx), ldst_rdata, v.e_data);
      chk($sformatf("v%0d pf", idx), 32'(ldst_pf), 32'(v.pf));
      chk($sformatf("v%0d flags", idx), 32'(ldst_flags), 32'(v.flags));
      chk($sformatf("v%0d done_busy", idx), 32'(ldst_busy), 32'd0);
      chk($sformatf("v%0d done_req", idx), 32'(dio_req), 32'd0);
      $display("txn %0d: order=%0d rw=%0d addr=0x%08h dmask=%b data=0x%08h pf=%0d flags=0x%04h",
               idx, v.order, v.rw, v.addr, dio_mask, ldst_rdata, ldst_pf, ldst_flags);
   endtask

   initial begin
      //              order  mask     rw   addr          wdata         rdata         pf    flags     stall daddr         dmask    dwdata        data
      vecs[0] = '{2'b10, 4'b1111, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 14'h0003, 0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[1] = '{2'b00, 4'b1111, 1'b0, 32'h0000_0103, 32'h0000_0000, 32'h1122_3344, 1'b0, 14'h0000, 0, 32'h0000_0100, 4'b0001, 32'h0000_0000, 32'h0000_0044};
      vecs[2] = '{2'b01, 4'b1111, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h1122_3344, 1'b0, 14'h0010, 0, 32'h0000_0100, 4'b0011, 32'h0000_0000, 32'h0000_3344};
      vecs[3] = '{2'b00, 4'b1111, 1'b1, 32'h0000_0201, 32'h0000_00A5, 32'h1234_5678, 1'b0, 14'h0000, 0, 32'h0000_0200, 4'b0100, 32'hA5A5_A5A5, 32'h0000_0000};
      vecs[4] = '{2'b10, 4'b1111, 1'b0, 32'h0000_0300, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 14'h0155, 0, 32'h0000_0300, 4'b1111, 32'h0000_0000, 32'h0000_0000};
      vecs[5] = '{2'b10, 4'b1111, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0102_0304, 1'b0, 14'h0000, 4, 32'h0000_0400, 4'b1111, 32'h0000_0000, 32'h0102_0304};
      vecs[6] = '{2'b01, 4'b1111, 1'b1, 32'h0000_0200, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 14'h0000, 0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0000};
      vecs[7] = '{2'b00, 4'b0111, 1'b0, 32'h0000_0500, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 14'h0022, 0, 32'h0000_0500, 4'b0000, 32'h0000_0000, 32'h0000_00CA};

      ldst_req = 0; ldst_order = 0; ldst_mask = 0; ldst_rw = 0; ldst_tid = 0;
      ldst_mmumod = 0; ldst_pdt = 0; ldst_addr = 0; ldst_wdata = 0;
      dio_busy = 0; dio_valid = 0; dio_pf = 0; dio_flags = 0; dio_rdata = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst busy", 32'(ldst_busy), 32'd0);
      chk("rst valid", 32'(ldst_valid), 32'd0);
      chk("rst dreq", 32'(dio_req), 32'd0);
      chk("rst data", ldst_rdata, 32'd0);
      chk("rst flags", 32'(ldst_flags), 32'd0);
      chk("rst daddr", dio_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

      // Pulse only, results held.
      ldst_req = 1'b0;
      @(negedge clk);
      chk("hold valid", 32'(ldst_valid), 32'd0);
      chk("hold data", ldst_rdata, 32'h0000_00CA);
      chk("hold flags", 32'(ldst_flags), 32'h0022);

      // Reset while waiting for memory: abort, then stray completion ignored.
      ldst_req = 1'b1; ldst_order = 2'b10; ldst_mask = 4'b1111; ldst_rw = 1'b0;
      ldst_addr = 32'h0000_0600;
      @(negedge clk);
      ldst_req = 1'b0;
      @(negedge clk);
      chk("rstw in_wait", 32'(ldst_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstw busy", 32'(ldst_busy), 32'd0);
      chk("rstw dreq", 32'(dio_req), 32'd0);
      chk("rstw data", ldst_rdata, 32'd0);
      chk("rstw flags", 32'(ldst_flags), 32'd0);
      chk("rstw daddr", dio_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dio_valid = 1'b1; dio_rdata = 32'h7777_7777; dio_flags = 14'h0011;
      @(negedge clk);
      dio_valid = 1'b0;
      chk("late valid", 32'(ldst_valid), 32'd0);
      chk("late data", ldst_rdata, 32'd0);
      chk("late busy", 32'(ldst_busy), 32'd0);
      $display("txn reset-abort: busy=%0d valid=%0d data=0x%08h", ldst_busy, ldst_valid, ldst_rdata);

      // Put a nonzero result in place, then a no-op must clear it.
      run_txn(8, vecs[0]);
      ldst_req = 1'b1; ldst_order = 2'b11; ldst_addr = 32'h0000_0700;
      @(negedge clk);
      ldst_req = 1'b0;
      chk("nop valid", 32'(ldst_valid), 32'd1);
      chk("nop data", ldst_rdata, 32'd0);
      chk("nop pf", 32'(ldst_pf), 32'd0);
      chk("nop flags", 32'(ldst_flags), 32'd0);
      chk("nop dreq", 32'(dio_req), 32'd0);
      @(negedge clk);
      chk("nop after valid", 32'(ldst_valid), 32'd0);
      chk("nop after dreq", 32'(dio_req), 32'd0);
      chk("nop after busy", 32'(ldst_busy), 32'd0);
      $display("txn nop: valid pulse observed, data=0x%08h", ldst_rdata);

`ifdef LDST_ALIGN_CHECK_EN
      ldst_req = 1'b1; ldst_order = 2'b10; ldst_addr = 32'h0000_0102;
      @(negedge clk);
      ldst_req = 1'b0;
      chk("mis valid", 32'(ldst_valid), 32'd1);
      chk("mis pf", 32'(ldst_pf), 32'd1);
      chk("mis flags", 32'(ldst_flags), 32'h0001);
      chk("mis data", ldst_rdata, 32'd0);
      chk("mis dreq", 32'(dio_req), 32'd0);
      @(negedge clk);
      chk("mis after dreq", 32'(dio_req), 32'd0);
      $display("txn misalign: pf=%0d flags=0x%04h", ldst_pf, ldst_flags);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
